// File: rtl/tns_decoder_06.sv
// tns_decoder_06 : receiver-side decoder for the 6-bit two-group TNS
// crosstalk-avoidance codeword.
//
// Each accepted codeword is turned back into a BLEN-bit binary word. The
// decoder is a two-stage pipeline with valid qualification. Stage 1
// registers the two group sums. Stage 2 adds them and presents the result.
// Latency is two clocks and throughput is one codeword per clock.
//
// Optional feature, enabled by defining TNS_DEC_ERRCHK_EN:
//   The decoder remembers the previous codeword's group-leading bits
//   (c5, c2). It flags codewords that a correct encoder could never emit,
//   and keeps a saturating count of those codewords.
//   When TNS_DEC_ERRCHK_EN is not defined, code_err and err_cnt are tied
//   to 0. Decode and latency are the same in both builds.

module tns_decoder_06 #(
   parameter int BLEN = 5,
   parameter int W_A2 = 10,
   parameter int W_B2 = 5,
   parameter int W_C2 = 5,
   parameter int W_A1 = 2,
   parameter int W_B1 = 1
) (
   input  logic            clock,
   input  logic            rst_n,
   input  logic [5:0]      code_in,
   input  logic            code_valid,
   output logic [BLEN-1:0] data_out,
   output logic            data_valid,
   output logic            code_err,
   output logic [7:0]      err_cnt
);

   // Weight carried by each code bit. Bit 0 always weighs 1.
   function automatic int bit_weight(input int idx);
      int w;
      case (idx)
         5:       w = W_A2;
         4:       w = W_B2;
         3:       w = W_C2;
         2:       w = W_A1;
         1:       w = W_B1;
         default: w = 1;
      endcase
      return w;
   endfunction

   // ------------------------------------------------------------------
   // Weighted terms, one per code bit
   // ------------------------------------------------------------------
   logic [BLEN-1:0] term [6];

   for (genvar gi = 0; gi < 6; gi++) begin : g_term
      assign term[gi] = code_in[gi] ? BLEN'(bit_weight(gi)) : '0;
   end

   logic [BLEN-1:0] g2_next;
   logic [BLEN-1:0] g1_next;

   assign g2_next = term[5] + term[4] + term[3];
   assign g1_next = term[2] + term[1] + term[0];

   // ------------------------------------------------------------------
   // Stage 1 : group sums
   // ------------------------------------------------------------------
   logic            s1_valid_reg;
   logic [BLEN-1:0] s1_g2_reg;
   logic [BLEN-1:0] s1_g1_reg;

   // Capture the group sums of each accepted codeword. A bubble holds the
   // sums and only clears the valid flag.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_g2_reg    <= '0;
         s1_g1_reg    <= '0;
      end else begin
         s1_valid_reg <= code_valid;
         if (code_valid) begin
            s1_g2_reg <= g2_next;
            s1_g1_reg <= g1_next;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2 : decoded word
   // ------------------------------------------------------------------
   logic [BLEN-1:0] data_out_reg;
   logic            data_valid_reg;

   // Add the group sums. data_out keeps its last value across bubbles.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         data_out_reg   <= '0;
         data_valid_reg <= 1'b0;
      end else begin
         data_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            data_out_reg <= s1_g2_reg + s1_g1_reg;
         end
      end
   end

   assign data_out   = data_out_reg;
   assign data_valid = data_valid_reg;

`ifdef TNS_DEC_ERRCHK_EN
   // ------------------------------------------------------------------
   // Code-rule checking
   // ------------------------------------------------------------------
   logic        prev5_reg;
   logic        prev2_reg;
   logic        s1_err_reg;
   logic        code_err_reg;
   logic [7:0]  err_cnt_reg;

   logic [31:0] res2;
   logic [31:0] res1;
   logic        pat2_bad;
   logic        pat1_bad;
   logic        trans2_bad;
   logic        trans1_bad;
   logic        err_next;

   // Group residues, and the illegal-pattern and forbidden-transition tests.
   // A leading bit that flips may not land its group residue inside the
   // window just above the leading weight. The encoder never produces that
   // step.
   always_comb begin
      res2 = (code_in[5] ? 32'(W_A2) : 32'd0)
           + (code_in[4] ? 32'(W_B2) : 32'd0)
           + (code_in[3] ? 32'(W_C2) : 32'd0);
      res1 = (code_in[2] ? 32'(W_A1) : 32'd0)
           + (code_in[1] ? 32'(W_B1) : 32'd0)
           + (code_in[0] ? 32'd1     : 32'd0);

      pat2_bad   = !code_in[4] && code_in[3];
      pat1_bad   = !code_in[1] && code_in[0];
      trans2_bad = (code_in[5] != prev5_reg)
                && (res2 >= 32'(W_A2)) && (res2 < 32'(W_A2 + W_C2));
      trans1_bad = (code_in[2] != prev2_reg)
                && (res1 >= 32'(W_A1)) && (res1 < 32'(W_A1 + 1));
      err_next   = pat2_bad || pat1_bad || trans2_bad || trans1_bad;
   end

   // Leading-bit history and the stage-1 error flag. Both advance on every
   // accepted codeword, including erroneous ones.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         prev5_reg  <= 1'b0;
         prev2_reg  <= 1'b0;
         s1_err_reg <= 1'b0;
      end else if (code_valid) begin
         prev5_reg  <= code_in[5];
         prev2_reg  <= code_in[2];
         s1_err_reg <= err_next;
      end
   end

   // Present the error flag alongside its word. The counter is updated on
   // the same edge, so it already includes the word that is showing.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         code_err_reg <= 1'b0;
         err_cnt_reg  <= '0;
      end else begin
         code_err_reg <= s1_valid_reg && s1_err_reg;
         if (s1_valid_reg && s1_err_reg && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
         end
      end
   end

   assign code_err = code_err_reg;
   assign err_cnt  = err_cnt_reg;
`else
   assign code_err = 1'b0;
   assign err_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_tns_decoder_06.sv
// tb_tns_decoder_06 : self-checking bench for tns_decoder_06.
// The bench runs a directed stream with hand-computed results, then random
// codewords. A behavioural model checks every cycle.
// Error expectations follow TNS_DEC_ERRCHK_EN, the same as the design.

module tb_tns_decoder_06;

   logic       clock;
   logic       rst_n;
   logic [5:0] code_in;
   logic       code_valid;
   logic [4:0] data_out;
   logic       data_valid;
   logic       code_err;
   logic [7:0] err_cnt;

   int n_cmp;
   int n_bad;

   tns_decoder_06 dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .code_in    (code_in),
      .code_valid (code_valid),
      .data_out   (data_out),
      .data_valid (data_valid),
      .code_err   (code_err),
      .err_cnt    (err_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

`ifdef TNS_DEC_ERRCHK_EN
   localparam bit ERRCHK = 1'b1;
`else
   localparam bit ERRCHK = 1'b0;
`endif

   // ---------------- reference arithmetic ----------------
   function automatic logic [4:0] ref_decode(input logic [5:0] c);
      int s;
      s = 10*int'(c[5]) + 5*int'(c[4]) + 5*int'(c[3])
        + 2*int'(c[2]) + int'(c[1]) + int'(c[0]);
      return 5'(s % 32);
   endfunction

   function automatic bit ref_err(input logic [5:0] c, input bit p5, input bit p2);
      int r2;
      int r1;
      bit e;
      r2 = 10*int'(c[5]) + 5*int'(c[4]) + 5*int'(c[3]);
      r1 = 2*int'(c[2]) + int'(c[1]) + int'(c[0]);
      e  = (c[4] == 1'b0 && c[3] == 1'b1) || (c[1] == 1'b0 && c[0] == 1'b1)
        || (c[5] != p5 && r2 >= 10 && r2 < 15)
        || (c[2] != p2 && r1 >= 2 && r1 < 3);
      return e && ERRCHK;
   endfunction

   // ---------------- behavioural model ----------------
   bit       m_p5, m_p2;
   bit       pend_v;
   bit [4:0] pend_d;
   bit       pend_e;
   bit       exp_dv;
   bit [4:0] exp_data;
   bit       exp_err;
   int       exp_cnt;

   // The expected outputs follow the word accepted one edge earlier.
   always @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         m_p5 = 0; m_p2 = 0; pend_v = 0; pend_d = 0; pend_e = 0;
         exp_dv = 0; exp_data = 0; exp_err = 0; exp_cnt = 0;
      end else begin
         exp_dv = pend_v;
         if (pend_v) begin
            exp_data = pend_d;
            exp_err  = pend_e;
            if (pend_e && exp_cnt < 255) exp_cnt = exp_cnt + 1;
         end else begin
            exp_err = 0;
         end
         pend_v = code_valid;
         if (code_valid) begin
            pend_d = ref_decode(code_in);
            pend_e = ref_err(code_in, m_p5, m_p2);
            m_p5   = code_in[5];
            m_p2   = code_in[2];
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Literal expectations for directed words, in arrival order.
   typedef struct { int d; int e; int n; } lit_t;
   lit_t lit_q[$];

   task automatic push_lit(input int d, input int e, input int n);
      lit_t l;
      l.d = d;
      l.e = ERRCHK ? e : 0;
      l.n = ERRCHK ? n : 0;
      lit_q.push_back(l);
   endtask

   // Per-cycle compare against the model and the literal table.
   always @(negedge clock) begin
      chk("data_valid", int'(data_valid), int'(exp_dv));
      chk("data_out", int'(data_out), int'(exp_data));
      if (exp_dv) chk("code_err", int'(code_err), int'(exp_err));
      chk("err_cnt", int'(err_cnt), exp_cnt);
      if (rst_n && data_valid && lit_q.size() > 0) begin
         lit_t l;
         l = lit_q.pop_front();
         chk("lit_data", int'(data_out), l.d);
         chk("lit_err", int'(code_err), l.e);
         chk("lit_cnt", int'(err_cnt), l.n);
      end
   end

   task automatic drive(input logic v, input logic [5:0] c);
      @(posedge clock);
      #1;
      code_valid = v;
      code_in    = c;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      code_valid = 1'b0;
      code_in = 6'd0;
      repeat (3) @(posedge clock);
      #1 rst_n = 1'b1;

      // Single word, then a legal encoder stream.
      push_lit(12, 0, 0); drive(1, 6'b011011);
      drive(0, 6'b000000);
      push_lit(12, 0, 0); drive(1, 6'b011011);
      push_lit(24, 0, 0); drive(1, 6'b111111);
      push_lit(12, 0, 0); drive(1, 6'b100100);
      push_lit(24, 0, 0); drive(1, 6'b111111);
      // Forbidden transitions, then illegal patterns.
      push_lit(12, 1, 1); drive(1, 6'b011011);
      push_lit(5, 1, 2);  drive(1, 6'b001000);
      push_lit(1, 1, 3);  drive(1, 6'b000001);
      // Alternating valid.
      push_lit(0, 0, 3);  drive(1, 6'b000000);
      drive(0, 6'b111111);
      push_lit(2, 0, 3);  drive(1, 6'b000011);
      drive(0, 6'b000000);
      repeat (3) drive(0, 6'b000000);

      // Reset with words in flight. Neither word may surface.
      drive(1, 6'b111111);
      drive(1, 6'b111111);
      rst_n = 1'b0;
      code_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1 rst_n = 1'b1;
      repeat (3) drive(0, 6'b000000);
      push_lit(12, 1, 1); drive(1, 6'b100100);
      repeat (3) drive(0, 6'b000000);
      if (lit_q.size() != 0) begin
         chk("lit_pending", lit_q.size(), 0);
         lit_q.delete();
      end

      // Random stream. It produces enough errors to reach counter saturation.
      for (int i = 0; i < 3000; i++) begin
         drive(logic'($urandom_range(0, 3) != 0), 6'($urandom_range(0, 63)));
      end
      repeat (4) drive(0, 6'b000000);
      if (ERRCHK) chk("err_cnt_saturated", int'(err_cnt), 255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
